remote_cmd_sequencer: RTL and testbench
=======================================

Name: remote_cmd_sequencer

Overview:
- Synthesizable command sequencer sitting directly upstream of remoteComm.
- Drives remoteComm's cmd/send_cmd handshake from an internal command buffer. Waits for cmd_sent and then resp_rdy, checks each response byte against the expected acknowledge, and counts passes and fails.
- Replaces hand-written per-command bench tasks, e.g. calibrate 16'h2000 followed by move commands 16'h4001, 16'h43F1, and so on.
- Usable in benches and in an FPGA self-test harness.

Parameters:
- DEPTH, 16, number of command buffer entries; power of 2.
- TIMEOUT_CYC, 80000000, clocks allowed between cmd_sent and resp_rdy before abort.
- EXP_RESP, 8'hA5, expected acknowledge byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write wr_data into buffer[wr_addr]; ignored while busy
- wr_addr  in  $clog2(DEPTH)  buffer write index
- wr_data  in  16  command word
- len  in  $clog2(DEPTH)+1  number of commands to play; sampled on start
- start  in  1  begin playback from index 0; ignored while busy
- cmd  out  16  command to remoteComm
- send_cmd  out  1  one-cycle send strobe to remoteComm
- cmd_sent  in  1  remoteComm transmit-complete
- resp_rdy  in  1  remoteComm response valid
- resp  in  8  remoteComm response byte
- busy  out  1  sequence in progress
- done  out  1  sticky; sequence finished or aborted
- pass_cnt  out  $clog2(DEPTH)+1  responses equal to EXP_RESP
- fail_cnt  out  $clog2(DEPTH)+1  responses not equal to EXP_RESP
- timeout_err  out  1  sticky; response timeout occurred
- err_idx  out  $clog2(DEPTH)  index of first failure or timeout

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: cmd=0, send_cmd=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, timeout_err=0, err_idx=0, state=IDLE.
  - The buffer contents are not reset.
- Reset mid-sequence aborts at the next edge. No further send_cmd is issued.
- Buffer: DEPTH x 16 register array.
  - Write takes effect at the clock edge.
  - A write and a start in the same cycle: the write lands first; playback sees the new data.
- States: IDLE, ISSUE, WAIT_SENT, WAIT_RESP, NEXT, FINISH.
- IDLE, on start:
  - Capture len. Clear done, counters, timeout_err and err_idx. Set idx=0, busy=1.
  - If len==0, go to FINISH. Otherwise go to ISSUE.
  - len > DEPTH is clamped to DEPTH.
- ISSUE: cmd <= buffer[idx]; send_cmd=1 for exactly this one cycle; go to WAIT_SENT.
  - cmd holds its value until the next ISSUE.
- WAIT_SENT: wait for cmd_sent=1, then clear the timeout counter and go to WAIT_RESP.
  - A resp_rdy rising edge seen in this state is latched as pending and is consumed on entry to WAIT_RESP.
- WAIT_RESP:
  - A response is accepted on a resp_rdy rising edge (resp_rdy=1 and its registered previous value=0), or from the pending latch. resp is compared in the same cycle.
  - Equal: pass_cnt++. Not equal: fail_cnt++; if this is the first error, err_idx=idx. Then go to NEXT.
  - The timeout counter increments each cycle. When it reaches TIMEOUT_CYC-1 with no response: set timeout_err=1; set err_idx=idx if no earlier error; go to FINISH.
  - A response on the same cycle as the timeout wins; no timeout is flagged.
- NEXT: idx++. If idx==len_captured, go to FINISH; otherwise go to ISSUE.
  - This gives 2 idle cycles between a response and the next send_cmd.
- FINISH: busy=0, done=1, then IDLE. done stays high until the next start or reset.
- Counter widths: counters never wrap, since the maximum value is DEPTH. The timeout counter is $clog2(TIMEOUT_CYC) bits and saturates.
- start while busy: ignored. wr_en while busy: ignored.

Optional Feature:
- Macro: SEQ_STOP_ON_FAIL_EN
- Defined: the first response mismatch goes straight to FINISH after updating fail_cnt and err_idx. Remaining commands are not sent.
- Undefined: mismatches are counted and playback continues to len. Only a timeout aborts.

Decomposition:
- Package remote_seq_pkg:
  - state enum typedef.
  - ACK_BYTE=8'hA5.
  - Command opcode constants CMD_CAL=16'h2000 and CMD_MOVE_BASE=16'h4000.
- Sub-module resp_timer: loadable clear plus saturating count with an expired flag, parameterized by TIMEOUT_CYC.
- The remainder is a single FSM module.

Test Plan:
- Load 2000,4001,43F1,47F1,4BF1 and set len=5. Model answers A5 after each cmd_sent. Required: 5 one-cycle send_cmd pulses in buffer order, pass_cnt=5, fail_cnt=0, done=1, busy=0.
- Same load; model answers 5A to the 3rd command. Required without the macro: pass_cnt=4, fail_cnt=1, err_idx=2, 5 sends. Required with SEQ_STOP_ON_FAIL_EN: 3 sends, pass=2, fail=1.
- TIMEOUT_CYC=100; model never asserts resp_rdy after command 1. Required: timeout_err=1, err_idx=1, done exactly 99 cycles after WAIT_RESP entry, no 3rd send_cmd.
- len=0, start. Required: done=1 within 2 cycles, no send_cmd, counters 0.
- Assert rst for 1 cycle during WAIT_RESP of command 2. Required: all outputs at reset values next cycle; no send_cmd until a new start.
- Hold resp_rdy high across two commands. Required: only edges (or the pending latch) count; pass_cnt never exceeds the number of commands sent.

Source files
------------

// File: rtl/remote_seq_pkg.sv
// Shared definitions for the remote command sequencer.
//   seq_state_t   : playback FSM states
//   ACK_BYTE      : acknowledge byte remoteComm returns for a good command
//   CMD_CAL       : calibrate opcode
//   CMD_MOVE_BASE : base opcode for move commands (low bits carry the move)
package remote_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SENT,
        WAIT_RESP,
        NEXT,
        FINISH
    } seq_state_t;

    localparam logic [7:0]  ACK_BYTE      = 8'hA5;
    localparam logic [15:0] CMD_CAL       = 16'h2000;
    localparam logic [15:0] CMD_MOVE_BASE = 16'h4000;

endpackage

// File: rtl/resp_timer.sv
// Response timeout counter.
// The count clears on 'clear' and advances on 'enable', saturating at
// TIMEOUT_CYC-1. 'expired' is high on an enabled cycle whose increment takes
// the count to TIMEOUT_CYC-1 (or when it already sits there), so the caller
// can abort on the same edge at which the count reaches its limit.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clear   : load zero
//   enable  : count this cycle
//   expired : limit reached on this cycle
module resp_timer #(
    parameter int TIMEOUT_CYC = 80000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] PRE_LAST = TW'(TIMEOUT_CYC - 2);

    logic [TW-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + TW'(1);
        end
    end

    assign expired = enable && (count >= PRE_LAST);

endmodule

// File: rtl/remote_cmd_sequencer.sv
// Command sequencer feeding remoteComm from a small command buffer.
// Plays buffer[0 .. len-1] one command at a time: pulses send_cmd, waits for
// cmd_sent, then for a response byte, and scores it against EXP_RESP.
// Optional build macro SEQ_STOP_ON_FAIL_EN: the first mismatching response
// ends playback instead of continuing to the next command.
//   clk, rst     : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : buffer write port (ignored while busy)
//   len, start   : command count and playback trigger (ignored while busy)
//   cmd, send_cmd: command word and one-cycle send strobe to remoteComm
//   cmd_sent, resp_rdy, resp : remoteComm status and response byte
//   busy, done   : playback running / sticky finished-or-aborted
//   pass_cnt, fail_cnt : matching / mismatching responses
//   timeout_err, err_idx : sticky timeout flag, index of first error
module remote_cmd_sequencer
    import remote_seq_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         TIMEOUT_CYC = 80000000,
    parameter logic [7:0] EXP_RESP    = ACK_BYTE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [15:0]                wr_data,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       start,
    output logic [15:0]                cmd,
    output logic                       send_cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     pass_cnt,
    output logic [$clog2(DEPTH):0]     fail_cnt,
    output logic                       timeout_err,
    output logic [$clog2(DEPTH)-1:0]   err_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   buffer [DEPTH];
    seq_state_t    state;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_inc;
    logic [CW-1:0] len_q;
    logic [CW-1:0] len_clamped;
    logic          resp_rdy_q;
    logic          pend;
    logic [7:0]    pend_resp;
    logic          resp_rise;
    logic          accept;
    logic [7:0]    resp_byte;
    logic          tmr_clear;
    logic          tmr_expired;

    // NOTE: the command buffer has no reset; playback only reads entries
    // that were written, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    assign len_clamped = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;
    assign idx_inc     = idx + CW'(1);

    // Only a rising edge of resp_rdy is a new response; a level held across
    // commands must not be counted twice. An edge that arrives before
    // cmd_sent is parked in pend/pend_resp and consumed in WAIT_RESP.
    assign resp_rise = resp_rdy && !resp_rdy_q;
    assign accept    = pend || resp_rise;
    assign resp_byte = pend ? pend_resp : resp;

    assign tmr_clear = (state == WAIT_SENT) && cmd_sent;

    resp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_resp_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (state == WAIT_RESP),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= '0;
            send_cmd    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
            err_idx     <= '0;
            idx         <= '0;
            len_q       <= '0;
            resp_rdy_q  <= 1'b0;
            pend        <= 1'b0;
            pend_resp   <= '0;
        end else begin
            send_cmd   <= 1'b0;
            resp_rdy_q <= resp_rdy;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q       <= len_clamped;
                        done        <= 1'b0;
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        timeout_err <= 1'b0;
                        err_idx     <= '0;
                        idx         <= '0;
                        pend        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (len_clamped == '0) ? FINISH : ISSUE;
                    end
                end

                ISSUE: begin
                    cmd      <= buffer[idx[AW-1:0]];
                    send_cmd <= 1'b1;
                    pend     <= 1'b0;
                    state    <= WAIT_SENT;
                end

                WAIT_SENT: begin
                    if (resp_rise) begin
                        pend      <= 1'b1;
                        pend_resp <= resp;
                    end
                    if (cmd_sent) begin
                        state <= WAIT_RESP;
                    end
                end

                WAIT_RESP: begin
                    // A response on the timeout cycle takes priority.
                    if (accept) begin
                        pend <= 1'b0;
                        if (resp_byte == EXP_RESP) begin
                            pass_cnt <= pass_cnt + CW'(1);
                            state    <= NEXT;
                        end else begin
                            fail_cnt <= fail_cnt + CW'(1);
                            if (fail_cnt == '0) begin
                                err_idx <= idx[AW-1:0];
                            end
`ifdef SEQ_STOP_ON_FAIL_EN
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
`else
                            state <= NEXT;
`endif
                        end
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        if (fail_cnt == '0) begin
                            err_idx <= idx[AW-1:0];
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end

                NEXT: begin
                    idx <= idx_inc;
                    if (idx_inc == len_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        state <= ISSUE;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
module tb_remote_cmd_sequencer;
    import remote_seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 100;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  len;
    logic        start;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic [4:0]  pass_cnt;
    logic [4:0]  fail_cnt;
    logic        timeout_err;
    logic [3:0]  err_idx;

    remote_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO),
        .EXP_RESP    (ACK_BYTE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .len         (len),
        .start       (start),
        .cmd         (cmd),
        .send_cmd    (send_cmd),
        .cmd_sent    (cmd_sent),
        .resp_rdy    (resp_rdy),
        .resp        (resp),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .timeout_err (timeout_err),
        .err_idx     (err_idx)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_sent   = 0;
    int          cyc      = 0;
    int          rsp_idx  = 0;
    int          entry_cyc = 0;
    int          bad_idx  = -1;
    int          silent_from = -1;
    bit          hold_mode  = 1'b0;
    bit          early_mode = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] prog [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every send_cmd pulse pops the next expected word.
    initial begin : monitor
        logic        prev_send;
        logic [15:0] exp_word;
        prev_send = 1'b0;
        forever begin
            @(negedge clk);
            if (send_cmd) begin
                n_sent++;
                check("send_single_cycle", {31'd0, prev_send}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_send_cmd", {31'd0, send_cmd}, 32'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("send_cmd_word", {16'd0, cmd}, {16'd0, exp_word});
                end
            end
            prev_send = send_cmd;
        end
    end

    // remoteComm model: answers each send_cmd according to the test mode.
    initial begin : responder
        int k;
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        resp     = 8'h00;
        forever begin
            @(negedge clk);
            if (send_cmd) begin
                k = rsp_idx;
                rsp_idx++;
                if (early_mode) begin
                    @(negedge clk);
                    resp     = (k == bad_idx) ? 8'h5A : ACK_BYTE;
                    resp_rdy = 1'b1;
                    @(negedge clk);
                    resp_rdy = 1'b0;
                    resp     = 8'h00;
                    @(negedge clk);
                    cmd_sent  = 1'b1;
                    entry_cyc = cyc + 1;
                    @(negedge clk);
                    cmd_sent = 1'b0;
                end else begin
                    repeat (2) @(negedge clk);
                    cmd_sent  = 1'b1;
                    entry_cyc = cyc + 1;
                    @(negedge clk);
                    cmd_sent = 1'b0;
                    if (silent_from < 0 || k < silent_from) begin
                        @(negedge clk);
                        resp     = (k == bad_idx) ? 8'h5A : ACK_BYTE;
                        resp_rdy = 1'b1;
                        @(negedge clk);
                        if (!hold_mode) begin
                            resp_rdy = 1'b0;
                            resp     = 8'h00;
                        end
                    end
                end
            end
        end
    end

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_seq(input logic [4:0] l, input bit do_wr, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        rsp_idx = 0;
        len = l; start = 1'b1;
        wr_en = do_wr; wr_addr = a; wr_data = d;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_sent(input int n, input int budget);
        for (int i = 0; i < budget && n_sent < n; i++) @(negedge clk);
        check("wait_sent", {31'd0, (n_sent >= n)}, 32'd1);
    endtask

    task automatic reset_modes();
        bad_idx = -1; silent_from = -1; hold_mode = 1'b0; early_mode = 1'b0;
        resp_rdy = 1'b0; resp = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        int base;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; start = 1'b0;
        prog[0] = CMD_CAL;
        prog[1] = CMD_MOVE_BASE | 16'h0001;
        prog[2] = CMD_MOVE_BASE | 16'h03F1;
        prog[3] = CMD_MOVE_BASE | 16'h07F1;
        prog[4] = CMD_MOVE_BASE | 16'h0BF1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_cmd", {16'd0, cmd}, 32'd0);
        check("rst_send_cmd", {31'd0, send_cmd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass_cnt", {27'd0, pass_cnt}, 32'd0);
        check("rst_fail_cnt", {27'd0, fail_cnt}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_err_idx", {28'd0, err_idx}, 32'd0);

        for (int i = 0; i < 5; i++) write_word(4'(i), prog[i]);

        // All five acknowledged; a write attempted while busy must be dropped
        base = n_sent;
        for (int i = 0; i < 5; i++) exp_q.push_back(prog[i]);
        start_seq(5'd5, 1'b0, 4'd0, 16'd0);
        wait_sent(base + 1, 50);
        check("busy_during_play", {31'd0, busy}, 32'd1);
        write_word(4'd0, 16'hFFFF);
        wait_done("t1_done", 400);
        check("t1_pass_cnt", {27'd0, pass_cnt}, 32'd5);
        check("t1_fail_cnt", {27'd0, fail_cnt}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_sends", n_sent - base, 32'd5);

        // Third command answered with 5A
        reset_modes();
        bad_idx = 2;
        base = n_sent;
`ifdef SEQ_STOP_ON_FAIL_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
`else
        for (int i = 0; i < 5; i++) exp_q.push_back(prog[i]);
`endif
        start_seq(5'd5, 1'b0, 4'd0, 16'd0);
        wait_done("t2_done", 400);
        repeat (10) @(negedge clk);
`ifdef SEQ_STOP_ON_FAIL_EN
        check("t2_pass_cnt", {27'd0, pass_cnt}, 32'd2);
        check("t2_sends", n_sent - base, 32'd3);
`else
        check("t2_pass_cnt", {27'd0, pass_cnt}, 32'd4);
        check("t2_sends", n_sent - base, 32'd5);
`endif
        check("t2_fail_cnt", {27'd0, fail_cnt}, 32'd1);
        check("t2_err_idx", {28'd0, err_idx}, 32'd2);
        check("t2_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Second command never answered: timeout
        reset_modes();
        silent_from = 1;
        base = n_sent;
        for (int i = 0; i < 2; i++) exp_q.push_back(prog[i]);
        start_seq(5'd5, 1'b0, 4'd0, 16'd0);
        wait_done("t3_done", 400);
        check("t3_done_latency", cyc - entry_cyc, 32'd99);
        repeat (10) @(negedge clk);
        check("t3_timeout_err", {31'd0, timeout_err}, 32'd1);
        check("t3_err_idx", {28'd0, err_idx}, 32'd1);
        check("t3_pass_cnt", {27'd0, pass_cnt}, 32'd1);
        check("t3_fail_cnt", {27'd0, fail_cnt}, 32'd0);
        check("t3_sends", n_sent - base, 32'd2);

        // len = 0
        reset_modes();
        base = n_sent;
        start_seq(5'd0, 1'b0, 4'd0, 16'd0);
        wait_done("t4_done_within_2", 2);
        repeat (5) @(negedge clk);
        check("t4_sends", n_sent - base, 32'd0);
        check("t4_pass_cnt", {27'd0, pass_cnt}, 32'd0);
        check("t4_fail_cnt", {27'd0, fail_cnt}, 32'd0);
        check("t4_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Reset while waiting for the second response
        reset_modes();
        silent_from = 1;
        base = n_sent;
        for (int i = 0; i < 2; i++) exp_q.push_back(prog[i]);
        start_seq(5'd5, 1'b0, 4'd0, 16'd0);
        wait_sent(base + 2, 100);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_cmd", {16'd0, cmd}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_pass_cnt", {27'd0, pass_cnt}, 32'd0);
        check("t5_err_idx", {28'd0, err_idx}, 32'd0);
        check("t5_timeout_err", {31'd0, timeout_err}, 32'd0);
        repeat (150) @(negedge clk);
        check("t5_sends", n_sent - base, 32'd2);
        check("t5_done_after", {31'd0, done}, 32'd0);

        // resp_rdy held high across commands: only the first edge counts
        reset_modes();
        hold_mode = 1'b1;
        base = n_sent;
        for (int i = 0; i < 2; i++) exp_q.push_back(prog[i]);
        start_seq(5'd3, 1'b0, 4'd0, 16'd0);
        wait_done("t6_done", 400);
        repeat (10) @(negedge clk);
        check("t6_pass_cnt", {27'd0, pass_cnt}, 32'd1);
        check("t6_pass_le_sent", {31'd0, (32'(pass_cnt) <= n_sent - base)}, 32'd1);
        check("t6_timeout_err", {31'd0, timeout_err}, 32'd1);
        check("t6_err_idx", {28'd0, err_idx}, 32'd1);
        check("t6_sends", n_sent - base, 32'd2);

        // Responses before cmd_sent (pending latch); write lands with start
        reset_modes();
        early_mode = 1'b1;
        bad_idx = 1;
        base = n_sent;
        exp_q.push_back(16'h4123);
        exp_q.push_back(prog[1]);
        start_seq(5'd2, 1'b1, 4'd0, 16'h4123);
        wait_done("t7_done", 400);
        repeat (10) @(negedge clk);
        check("t7_pass_cnt", {27'd0, pass_cnt}, 32'd1);
        check("t7_fail_cnt", {27'd0, fail_cnt}, 32'd1);
        check("t7_err_idx", {28'd0, err_idx}, 32'd1);
        check("t7_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("t7_sends", n_sent - base, 32'd2);
        check("sends_outstanding", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
